host_job_sequencer: RTL and testbench

- Sits between the host and `inference_accelerator`, and shares the external single-port RAM with the accelerator.
- Runs one job per host command:
  - streams input/weight words from the host into external RAM;
  - pulses the accelerator start;
  - hands RAM ownership to the accelerator until it reports done;
  - streams the result region back to the host under backpressure.

---
 rtl/host_job_sequencer.sv | 160 ++++++++++++++++
 tb/tb_host_job_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_job_sequencer.sv
// host_job_sequencer
//   Runs one accelerator job per host command:
//     1. loads host words into the external RAM;
//     2. pulses the accelerator start and hands it the RAM until acc_done;
//     3. reads the result region back and streams it to the host under backpressure.
//
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     cmd_go, cfg_*         job request and job configuration (latched in IDLE)
//     s_valid/s_data/s_ready         host input stream
//     m_valid/m_data/m_last/m_ready  host result stream
//     ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   external RAM port
//     ram_sel               1 = accelerator owns the RAM
//     acc_host_start, acc_ext_ram_start_addr, acc_done   accelerator control
//     busy, job_done        status

`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 16
`endif
`ifndef WID_RAM
`define WID_RAM 32
`endif

module host_job_sequencer #(
  parameter int unsigned ADDR_W = `ADDR_EXT_RAM,
  parameter int unsigned DATA_W = `WID_RAM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_go,
  input  logic [ADDR_W-1:0] cfg_load_addr,
  input  logic [ADDR_W-1:0] cfg_load_len,
  input  logic [ADDR_W-1:0] cfg_res_addr,
  input  logic [ADDR_W-1:0] cfg_res_len,
  input  logic [ADDR_W-1:0] cfg_acc_addr,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_sel,
  output logic              acc_host_start,
  output logic [ADDR_W-1:0] acc_ext_ram_start_addr,
  input  logic              acc_done,
  output logic              busy,
  output logic              job_done
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StRun, StDrain, StFinish
  } state_e;

  localparam logic [ADDR_W-1:0] LenOne = ADDR_W'(1);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_load_addr, r_load_len, r_res_addr, r_res_len, r_acc_addr;
  logic [ADDR_W-1:0] r_i;     // words loaded
  logic [ADDR_W-1:0] r_j;     // result reads issued
  logic [ADDR_W-1:0] r_k;     // result words popped (index of FIFO head)
  logic              r_pend;  // read issued last cycle, data lands this cycle
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr, r_rd_ptr;
  logic [1:0]        r_count;

  logic w_beat, w_issue, w_pop, w_nempty, w_last, w_credit;

  assign w_beat   = (r_state == StLoad) && s_valid;
  assign w_nempty = (r_count != 2'd0);
  assign w_pop    = w_nempty && m_ready;
  assign w_last   = (r_k == r_res_len - LenOne);
  // Occupancy including the read in flight must stay below the FIFO depth of 2.
  assign w_credit = ({1'b0, r_count} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop});
  assign w_issue  = (r_state == StDrain) && (r_j < r_res_len) && w_credit;

  assign s_ready                = (r_state == StLoad);
  assign ram_sel                = (r_state == StStart) || (r_state == StRun);
  assign acc_host_start         = (r_state == StStart);
  assign acc_ext_ram_start_addr = ram_sel ? r_acc_addr : '0;
  assign busy                   = (r_state != StIdle);
  assign job_done               = (r_state == StFinish);
  assign ram_en                 = w_beat || w_issue;
  assign ram_we                 = w_beat;
  assign ram_addr               = w_beat  ? r_load_addr + r_i :
                                  w_issue ? r_res_addr + r_j  : '0;
  assign ram_wdata              = w_beat ? s_data : '0;
  assign m_valid                = w_nempty;
  assign m_data                 = w_nempty ? r_fifo[r_rd_ptr] : '0;
  assign m_last                 = w_nempty && w_last;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (cmd_go) w_state_d = (cfg_load_len == '0) ? StStart : StLoad;
      StLoad:   if (w_beat && (r_i == r_load_len - LenOne)) w_state_d = StStart;
      StStart:  w_state_d = StRun;
      StRun:    if (acc_done) w_state_d = (r_res_len == '0) ? StFinish : StDrain;
      StDrain:  if (w_pop && w_last) w_state_d = StFinish;
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_load_addr <= '0;
      r_load_len  <= '0;
      r_res_addr  <= '0;
      r_res_len   <= '0;
      r_acc_addr  <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_pend      <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == StIdle) && cmd_go) begin
        r_load_addr <= cfg_load_addr;
        r_load_len  <= cfg_load_len;
        r_res_addr  <= cfg_res_addr;
        r_res_len   <= cfg_res_len;
        r_acc_addr  <= cfg_acc_addr;
        r_i         <= '0;
        r_j         <= '0;
        r_k         <= '0;
        r_pend      <= 1'b0;
        r_wr_ptr    <= 1'b0;
        r_rd_ptr    <= 1'b0;
        r_count     <= 2'd0;
      end else begin
        if (w_beat)  r_i <= r_i + LenOne;
        if (w_issue) r_j <= r_j + LenOne;
        r_pend <= w_issue;
        if (r_pend) begin
          r_fifo[r_wr_ptr] <= ram_rdata;
          r_wr_ptr         <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
          r_k      <= r_k + LenOne;
        end
        if (r_pend && !w_pop)      r_count <= r_count + 2'd1;
        else if (!r_pend && w_pop) r_count <= r_count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_host_job_sequencer.sv
// Self-checking bench for host_job_sequencer: table of jobs plus hand-written
// reset/corner sequences; RAM writes and result words are checked via scoreboards.
module tb_host_job_sequencer;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_go = 1'b0;
  logic [AW-1:0] cfg_load_addr = '0, cfg_load_len = '0, cfg_res_addr = '0;
  logic [AW-1:0] cfg_res_len = '0, cfg_acc_addr = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
  logic          ram_en, ram_we, ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          acc_host_start, acc_done = 1'b0, busy, job_done;
  logic [AW-1:0] acc_ext_ram_start_addr;

  always #5 clk = ~clk;

  host_job_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .cmd_go(cmd_go),
    .cfg_load_addr(cfg_load_addr), .cfg_load_len(cfg_load_len),
    .cfg_res_addr(cfg_res_addr), .cfg_res_len(cfg_res_len), .cfg_acc_addr(cfg_acc_addr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_sel(ram_sel),
    .acc_host_start(acc_host_start), .acc_ext_ram_start_addr(acc_ext_ram_start_addr),
    .acc_done(acc_done), .busy(busy), .job_done(job_done)
  );

  // External single-port RAM model (the accelerator model never accesses it).
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_done   = 0;
  int m_mode   = 0;   // 0: m_ready high, 1: toggling, 2: low

  logic [DW-1:0] ref_mem [256];
  logic [23:0]   wr_q [$];   // {addr, data}
  logic [16:0]   out_q [$];  // {data, last}

  typedef struct {
    logic [7:0]  la, ll, ra, rl, aa;
    logic [15:0] base;
    int          d, gap, mmode, exp_cyc;
    bit          poke;
  } job_t;
  job_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none (or timeout)", name);
  endtask

  task automatic check_zero(input string name);
    check(name, {s_ready, m_valid, m_data, m_last, ram_en, ram_we, ram_addr, ram_wdata,
                 ram_sel, acc_host_start, acc_ext_ram_start_addr, busy, job_done}, 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (m_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (acc_host_start) n_start++;
    if (job_done) n_done++;
  end

  // Write scoreboard and RAM ownership check.
  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst && ram_en) begin
      check("ram_owner", {63'd0, ram_sel}, 64'd0);
      if (ram_we) begin
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          e = wr_q.pop_front();
          check("wr_addr", {56'd0, ram_addr}, {56'd0, e[23:16]});
          check("wr_data", {48'd0, ram_wdata}, {48'd0, e[15:0]});
        end
      end
    end
  end

  // Result scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && m_valid && m_ready) begin
      if (out_q.size() == 0) fail_now("unexpected_output");
      else begin
        e = out_q.pop_front();
        check("out_word", {47'd0, m_data, m_last}, {47'd0, e});
      end
    end
  end

  // Output must hold while stalled.
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  always @(negedge clk) begin
    if (!rst && hold_q)
      check("out_stable", {46'd0, m_valid, m_data, m_last}, {46'd0, 1'b1, hold_d, hold_l});
    hold_q = !rst && m_valid && !m_ready;
    hold_d = m_data;
    hold_l = m_last;
  end

  task automatic run_job(input job_t j);
    int s0, d0;
    logic [7:0] a;
    cfg_load_addr = j.la;
    cfg_load_len  = j.ll;
    cfg_res_addr  = j.ra;
    cfg_res_len   = j.rl;
    cfg_acc_addr  = j.aa;
    for (int k = 0; k < int'(j.ll); k++) begin
      a = j.la + 8'(k);
      ref_mem[a] = j.base + 16'(k);
    end
    for (int k = 0; k < int'(j.rl); k++) begin
      a = j.ra + 8'(k);
      out_q.push_back({ref_mem[a], k == int'(j.rl) - 1});
    end
    m_mode = j.mmode;
    s0 = n_start;
    d0 = n_done;
    @(posedge clk); #1 cmd_go = 1'b1;
    @(posedge clk); #1 cmd_go = 1'b0;
    fork
      begin : drv
        int tries;
        for (int k = 0; k < int'(j.ll); k++) begin
          if (j.gap > 0 && k > 0) begin
            s_valid = 1'b0;
            repeat (j.gap) @(posedge clk);
            #1;
          end
          s_valid = 1'b1;
          s_data  = j.base + 16'(k);
          tries   = 0;
          while (!s_ready && tries < 50) begin
            @(posedge clk); #1;
            tries++;
          end
          if (s_ready) wr_q.push_back({j.la + 8'(k), s_data});
          else fail_now("s_ready_timeout");
          @(posedge clk); #1;
        end
        s_valid = 1'b0;
      end
      begin : acc
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
          @(negedge clk);
          if (acc_host_start) seen = 1'b1;
        end
        if (!seen) fail_now("acc_start_timeout");
        else begin
          check("acc_addr", {56'd0, acc_ext_ram_start_addr}, {56'd0, j.aa});
          check("start_ram_sel", {63'd0, ram_sel}, 64'd1);
          repeat (j.d) @(posedge clk);
          #1 acc_done = 1'b1;
          @(posedge clk); #1 acc_done = 1'b0;
        end
      end
      begin : wait_done
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        while (cyc < 500 && !got) begin
          @(negedge clk);
          cyc++;
          if (j.poke && cyc == 2) cmd_go = 1'b1;
          if (j.poke && cyc == 3) cmd_go = 1'b0;
          if (job_done) got = 1'b1;
        end
        if (!got) fail_now("job_done_timeout");
        else if (j.exp_cyc != 0) check("latency", 64'(cyc), 64'(j.exp_cyc));
      end
    join
    @(negedge clk);
    check("idle_after_job", {63'd0, busy}, 64'd0);
    check("start_pulses", 64'(n_start - s0), 64'd1);
    check("done_pulses", 64'(n_done - d0), 64'd1);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("out_q_empty", 64'(out_q.size()), 64'd0);
    m_mode = 0;
  endtask

  // Wait (bounded) for a condition sampled on the falling edge.
  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (acc_host_start) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    int d0;
    //         la     ll    ra     rl    aa     base      d  gap mm  cyc poke
    tbl[0] = '{8'h10, 8'd4, 8'h10, 8'd4, 8'h33, 16'h000A, 5, 0, 0, 17, 1'b1};
    tbl[1] = '{8'h00, 8'd0, 8'h00, 8'd0, 8'h55, 16'h0000, 1, 0, 0,  3, 1'b0};
    tbl[2] = '{8'hFE, 8'd4, 8'hFE, 8'd4, 8'h77, 16'h1230, 2, 0, 0, 14, 1'b0};
    tbl[3] = '{8'h40, 8'd6, 8'h40, 8'd6, 8'h11, 16'h0B00, 3, 0, 1,  0, 1'b0};
    tbl[4] = '{8'h80, 8'd3, 8'h80, 8'd3, 8'h22, 16'h0C00, 1, 3, 0,  0, 1'b0};
    tbl[5] = '{8'h20, 8'd2, 8'h00, 8'd0, 8'h66, 16'h0D00, 2, 0, 0,  6, 1'b0};
    tbl[6] = '{8'h00, 8'd0, 8'h10, 8'd2, 8'h44, 16'h0000, 1, 0, 0,  7, 1'b0};

    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b0;

    for (int r = 0; r < 7; r++) run_job(tbl[r]);

    // Reset during RUN; acc_done asserted during START must be ignored.
    d0 = n_done;
    cfg_load_addr = 8'h60; cfg_load_len = 8'd2;
    cfg_res_addr  = 8'h60; cfg_res_len  = 8'd3; cfg_acc_addr = 8'h99;
    @(posedge clk); #1 cmd_go = 1'b1;
    @(posedge clk); #1 cmd_go = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_data  = 16'h0E00 + 16'(k);
      check("rst_run_s_ready", {63'd0, s_ready}, 64'd1);
      wr_q.push_back({8'h60 + 8'(k), s_data});
      ref_mem[8'h60 + 8'(k)] = s_data;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    wait_start(seen);
    if (!seen) fail_now("rst_run_start_timeout");
    acc_done = 1'b1;
    @(posedge clk); #1 acc_done = 1'b0;
    @(negedge clk);
    check("done_ignored_in_start", {62'd0, ram_sel, busy}, 64'd3);
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_run");
    @(posedge clk); #1 rst = 1'b0;
    check("rst_run_no_done", 64'(n_done - d0), 64'd0);
    check("rst_run_wr_q", 64'(wr_q.size()), 64'd0);

    // Reset during DRAIN with the host stalled.
    d0 = n_done;
    m_mode = 2;
    cfg_load_len = 8'd0; cfg_res_addr = 8'h10; cfg_res_len = 8'd4;
    @(posedge clk); #1 cmd_go = 1'b1;
    @(posedge clk); #1 cmd_go = 1'b0;
    wait_start(seen);
    if (!seen) fail_now("rst_drain_start_timeout");
    @(posedge clk); #1 acc_done = 1'b1;
    @(posedge clk); #1 acc_done = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    if (!seen) fail_now("rst_drain_valid_timeout");
    else check("drain_head", {47'd0, m_data, m_last}, {47'd0, ref_mem[8'h10], 1'b0});
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_drain");
    @(posedge clk); #1 rst = 1'b0;
    m_mode = 0;
    check("rst_drain_no_done", 64'(n_done - d0), 64'd0);

    // A full job must still complete after the aborted ones.
    run_job(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
